// File: rtl/grid_scan_pkg.sv
// Shared game constants for the kitchen grid: object codes, grid dimensions,
// tile geometry and a helper that maps a tile index to its screen origin.
package grid_scan_pkg;

   localparam int GRID_COLS  = 13;
   localparam int GRID_ROWS  = 8;
   localparam int TILE_SIZE  = 32;
   localparam int TILE_SHIFT = 5;
   localparam int FRAME_W    = 8;

   typedef enum logic [3:0] {
      G_EMPTY         = 4'd0,
      G_COUNTER       = 4'd1,
      G_CUTTING_BOARD = 4'd2,
      G_STOVE         = 4'd3,
      G_POT           = 4'd4,
      G_PLATE         = 4'd5,
      G_SINK          = 4'd6,
      G_TRASH         = 4'd7,
      G_FIRE          = 4'd8,
      G_EXTINGUISHER  = 4'd9
   } grid_obj_e;

   typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0] grid_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [9:0]  vcount;
      logic        hsync;
      logic        vsync;
      logic        blank;
      logic        in_grid;
      logic [3:0]  col;
      logic [2:0]  row;
      logic [4:0]  u;
      logic [4:0]  v;
   } stage1_t;

   // Screen coordinate of the first pixel of tile 'idx' along one axis.
   function automatic logic [10:0] tile_origin(input logic [10:0] base,
                                               input logic [3:0]  idx);
      return base + {2'b00, idx, 5'b00000};
   endfunction

endpackage

// File: rtl/grid_scan_if.sv
// Pixel-timing and grid bundle between the video timing source, the grid
// scanner and the graphics compositor.
interface grid_scan_if;
   import grid_scan_pkg::*;

   // Free-running pixel stream: no valid/ready; every clock carries one pixel
   // and every output reflects the pixel presented two clocks earlier.
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync;
   logic        vsync;
   logic        blank;
   grid_t       object_grid;
   grid_t       time_grid;

   logic [3:0]  tile_obj;
   logic [3:0]  tile_time;
   logic [4:0]  tile_u;
   logic [4:0]  tile_v;
   logic [10:0] tile_x;
   logic [9:0]  tile_y;
   logic        in_grid;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        blank_out;
   logic [1:0]  anim_phase;

   modport slave (
      input  hcount, vcount, hsync, vsync, blank, object_grid, time_grid,
      output tile_obj, tile_time, tile_u, tile_v, tile_x, tile_y, in_grid,
             hcount_out, vcount_out, hsync_out, vsync_out, blank_out, anim_phase
   );

   modport master (
      output hcount, vcount, hsync, vsync, blank, object_grid, time_grid,
      input  tile_obj, tile_time, tile_u, tile_v, tile_x, tile_y, in_grid,
             hcount_out, vcount_out, hsync_out, vsync_out, blank_out, anim_phase
   );

endinterface

// File: rtl/grid_scan_vsync_edge.sv
// Registered falling-edge detector on vsync; marks the start of each frame.
module vsync_edge (
   input  logic clock,
   input  logic reset,
   input  logic vsync,
   output logic fall
);

   logic vsync_q;

   // Resets high so the first genuine falling edge after reset is seen.
   always_ff @(posedge clock) begin
      if (!reset) vsync_q <= 1'b1;
      else        vsync_q <= vsync;
   end

   assign fall = reset & vsync_q & ~vsync;

endmodule

// File: rtl/grid_scan.sv
// Two-stage grid scanner: maps each pixel to its kitchen tile and looks up
// the per-frame snapshot of object codes and timers for that tile.
module grid_scan
   import grid_scan_pkg::*;
#(
   parameter int GRID_X0  = 112,
   parameter int GRID_Y0  = 112,
   parameter int NUM_COLS = 13,
   parameter int NUM_ROWS = 8,
   parameter int ANIM_DIV = 8
) (
   input  logic       clock,
   input  logic       reset,
   grid_scan_if.slave bus
);

   localparam int X_END = GRID_X0 + TILE_SIZE * NUM_COLS;
   localparam int Y_END = GRID_Y0 + TILE_SIZE * NUM_ROWS;

   logic [8:0]         dx;
   logic [7:0]         dy;
   logic               in_grid_c;
   stage1_t            s1_next;
   stage1_t            s1;
   grid_t              snap_obj;
   grid_t              snap_time;
   logic               frame_fall;
   logic [FRAME_W-1:0] frame_cnt;
   logic [1:0]         anim_q;

   vsync_edge u_vsync_edge (
      .clock (clock),
      .reset (reset),
      .vsync (bus.vsync),
      .fall  (frame_fall)
   );

   // Only the low bits of the offsets are needed, so narrow subtractions suffice.
   assign dx = bus.hcount[8:0] - 9'(GRID_X0);
   assign dy = bus.vcount[7:0] - 8'(GRID_Y0);

   always_comb begin
      in_grid_c = (32'(bus.hcount) >= 32'(GRID_X0)) && (32'(bus.hcount) < 32'(X_END)) &&
                  (32'(bus.vcount) >= 32'(GRID_Y0)) && (32'(bus.vcount) < 32'(Y_END));
      s1_next         = '0;
      s1_next.hcount  = bus.hcount;
      s1_next.vcount  = bus.vcount;
      s1_next.hsync   = bus.hsync;
      s1_next.vsync   = bus.vsync;
      s1_next.blank   = bus.blank;
      s1_next.in_grid = in_grid_c;
      s1_next.col     = dx[8:5];
      s1_next.u       = dx[4:0];
      s1_next.row     = dy[7:5];
      s1_next.v       = dy[4:0];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1       <= '0;
         s1.hsync <= 1'b1;
         s1.vsync <= 1'b1;
         s1.blank <= 1'b1;
      end else begin
         s1 <= s1_next;
      end
   end

   // Grid state is frozen once per frame so a frame never shows a half update.
   always_ff @(posedge clock) begin
      if (!reset) begin
         snap_obj  <= {GRID_ROWS*GRID_COLS{G_EMPTY}};
         snap_time <= '0;
         frame_cnt <= '0;
         anim_q    <= '0;
      end else if (frame_fall) begin
         snap_obj  <= bus.object_grid;
         snap_time <= bus.time_grid;
         if (frame_cnt == FRAME_W'(ANIM_DIV - 1)) begin
            frame_cnt <= '0;
            anim_q    <= anim_q + 2'd1;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   assign bus.anim_phase = anim_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         bus.tile_obj   <= '0;
         bus.tile_time  <= '0;
         bus.tile_u     <= '0;
         bus.tile_v     <= '0;
         bus.tile_x     <= '0;
         bus.tile_y     <= '0;
         bus.in_grid    <= 1'b0;
         bus.hcount_out <= '0;
         bus.vcount_out <= '0;
         bus.hsync_out  <= 1'b1;
         bus.vsync_out  <= 1'b1;
         bus.blank_out  <= 1'b1;
      end else begin
         bus.hcount_out <= s1.hcount;
         bus.vcount_out <= s1.vcount;
         bus.hsync_out  <= s1.hsync;
         bus.vsync_out  <= s1.vsync;
         bus.blank_out  <= s1.blank;
         bus.in_grid    <= s1.in_grid;
         // Blanking is left to the compositor; tile data is never gated here.
         if (s1.in_grid) begin
            bus.tile_obj  <= snap_obj[s1.row][s1.col];
            bus.tile_time <= snap_time[s1.row][s1.col];
            bus.tile_u    <= s1.u;
            bus.tile_v    <= s1.v;
            bus.tile_x    <= tile_origin(11'(GRID_X0), s1.col);
            bus.tile_y    <= 10'(tile_origin(11'(GRID_Y0), {1'b0, s1.row}));
         end else begin
            bus.tile_obj  <= '0;
            bus.tile_time <= '0;
            bus.tile_u    <= '0;
            bus.tile_v    <= '0;
            bus.tile_x    <= '0;
            bus.tile_y    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan: expected outputs are queued at stimulus time
// and compared by a monitor two clocks later.
module tb_grid_scan;
   import grid_scan_pkg::*;

   typedef struct packed {
      logic [3:0]  obj;
      logic [3:0]  tim;
      logic [4:0]  u;
      logic [4:0]  v;
      logic [10:0] x;
      logic [9:0]  y;
      logic        in_g;
      logic [10:0] hc;
      logic [9:0]  vc;
      logic        hs;
      logic        vs;
      logic        bl;
   } exp_t;

   localparam int W = $bits(exp_t);

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   grid_scan_if bus ();

   grid_scan #(
      .GRID_X0  (112),
      .GRID_Y0  (112),
      .NUM_COLS (13),
      .NUM_ROWS (8),
      .ANIM_DIV (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   logic         issue    = 1'b0;
   logic [1:0]   vq       = 2'b00;
   logic [W-1:0] mon_e;
   string        mon_nm;

   function automatic exp_t got_now();
      exp_t g;
      g.obj  = bus.tile_obj;
      g.tim  = bus.tile_time;
      g.u    = bus.tile_u;
      g.v    = bus.tile_v;
      g.x    = bus.tile_x;
      g.y    = bus.tile_y;
      g.in_g = bus.in_grid;
      g.hc   = bus.hcount_out;
      g.vc   = bus.vcount_out;
      g.hs   = bus.hsync_out;
      g.vs   = bus.vsync_out;
      g.bl   = bus.blank_out;
      return g;
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // Latency tracker: marks which clock's outputs belong to a queued entry.
   always @(posedge clock) vq <= {vq[0], issue};

   always @(negedge clock) begin
      if (vq[1]) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL queue_underflow: got empty queue expected an entry");
         end else begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            check(mon_nm, got_now(), mon_e);
         end
      end
   end

   task automatic step(input logic [10:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic bl,
                       input logic [3:0] eo, input logic [3:0] et,
                       input logic [4:0] eu, input logic [4:0] ev,
                       input logic [10:0] ex, input logic [9:0] ey,
                       input logic ein, input string nm);
      exp_t e;
      @(posedge clock);
      #1;
      bus.hcount = h;
      bus.vcount = v;
      bus.hsync  = hs;
      bus.vsync  = vs;
      bus.blank  = bl;
      issue      = 1'b1;
      e.obj = eo;  e.tim = et;  e.u = eu;  e.v = ev;  e.x = ex;  e.y = ey;
      e.in_g = ein; e.hc = h;   e.vc = v;  e.hs = hs; e.vs = vs; e.bl = bl;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic idle(input logic hs, input logic vs, input logic bl, input string nm);
      step(11'd0, 10'd0, hs, vs, bl, 4'd0, 4'd0, 5'd0, 5'd0, 11'd0, 10'd0, 1'b0, nm);
   endtask

   task automatic pulse();
      idle(1'b1, 1'b0, 1'b1, "vsync_fall");
      idle(1'b1, 1'b1, 1'b1, "vsync_rise");
   endtask

   task automatic drain();
      @(posedge clock);
      #1;
      issue      = 1'b0;
      bus.hcount = '0;
      bus.vcount = '0;
      bus.hsync  = 1'b1;
      bus.vsync  = 1'b1;
      bus.blank  = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic check_reset_outputs(input string nm);
      exp_t r;
      r    = '0;
      r.hs = 1'b1;
      r.vs = 1'b1;
      r.bl = 1'b1;
      check(nm, got_now(), r);
      check({nm, "_anim"}, W'(bus.anim_phase), W'(0));
   endtask

   initial begin
      bus.hcount      = '0;
      bus.vcount      = '0;
      bus.hsync       = 1'b1;
      bus.vsync       = 1'b1;
      bus.blank       = 1'b1;
      bus.object_grid = '0;
      bus.time_grid   = '0;

      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset_state");
      reset = 1'b1;

      // Frame 1 contents
      bus.object_grid[0][0]  = 4'd1;  bus.time_grid[0][0]  = 4'd3;
      bus.object_grid[1][2]  = 4'd4;  bus.time_grid[1][2]  = 4'd2;
      bus.object_grid[7][12] = 4'd9;  bus.time_grid[7][12] = 4'd15;
      pulse();
      step(11'd112,  10'd112, 1'b1, 1'b1, 1'b0, 4'd1, 4'd3,  5'd0,  5'd0,  11'd112, 10'd112, 1'b1, "origin_tile");
      step(11'd111,  10'd112, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  5'd0,  5'd0,  11'd0,   10'd0,   1'b0, "left_of_grid");
      step(11'd112,  10'd111, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  5'd0,  5'd0,  11'd0,   10'd0,   1'b0, "above_grid");
      step(11'd200,  10'd150, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2,  5'd24, 5'd6,  11'd176, 10'd144, 1'b1, "mid_tile_blanked");
      step(11'd527,  10'd367, 1'b1, 1'b1, 1'b1, 4'd9, 4'd15, 5'd31, 5'd31, 11'd496, 10'd336, 1'b1, "last_pixel");
      step(11'd528,  10'd367, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  5'd0,  5'd0,  11'd0,   10'd0,   1'b0, "right_edge");
      step(11'd527,  10'd368, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  5'd0,  5'd0,  11'd0,   10'd0,   1'b0, "bottom_edge");
      step(11'd1500, 10'd200, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  5'd0,  5'd0,  11'd0,   10'd0,   1'b0, "far_right");

      // Mid-frame change must stay hidden until the next frame
      bus.object_grid[3][4] = 4'd7;
      bus.time_grid[3][4]   = 4'd1;
      step(11'd245, 10'd210, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd5, 5'd2, 11'd240, 10'd208, 1'b1, "mid_frame_hold");
      idle(1'b0, 1'b1, 1'b1, "hold_gap");
      step(11'd245, 10'd210, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd5, 5'd2, 11'd240, 10'd208, 1'b1, "mid_frame_hold2");
      pulse();
      step(11'd245, 10'd210, 1'b1, 1'b1, 1'b0, 4'd7, 4'd1, 5'd5, 5'd2, 11'd240, 10'd208, 1'b1, "after_capture");
      drain();

      // Reset coincident with a vsync falling edge
      for (int r = 0; r < GRID_ROWS; r++) begin
         for (int c = 0; c < GRID_COLS; c++) begin
            bus.object_grid[r][c] = 4'd5;
            bus.time_grid[r][c]   = 4'd6;
         end
      end
      reset     = 1'b0;
      bus.vsync = 1'b0;
      @(posedge clock);
      #1;
      bus.vsync = 1'b1;
      @(posedge clock);
      #1;
      check_reset_outputs("reset_on_edge");
      reset = 1'b1;
      step(11'd112, 10'd112, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd0,  5'd0,  11'd112, 10'd112, 1'b1, "no_capture_in_reset");
      step(11'd245, 10'd210, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd5,  5'd2,  11'd240, 10'd208, 1'b1, "snapshot_cleared");
      pulse();
      step(11'd112, 10'd112, 1'b1, 1'b1, 1'b0, 4'd5, 4'd6, 5'd0,  5'd0,  11'd112, 10'd112, 1'b1, "capture_after_reset");
      step(11'd527, 10'd367, 1'b1, 1'b1, 1'b1, 4'd5, 4'd6, 5'd31, 5'd31, 11'd496, 10'd336, 1'b1, "capture_after_reset_corner");

      // One edge already counted since reset; phase steps on edges 8,16,24,32
      check("anim_after_first_edge", W'(bus.anim_phase), W'(0));
      for (int k = 2; k <= 32; k++) begin
         pulse();
         check($sformatf("anim_phase_edge%0d", k), W'(bus.anim_phase), W'((k / 8) % 4));
      end

      // Random sync/blank stream must pass through with a two-clock delay
      for (int i = 0; i < 40; i++) begin
         idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "sync_stream");
      end
      drain();

      check("queue_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
